// File: rtl/aes_pkg.sv
// Shared AES constants and types: forward/inverse S-box tables, SubBytes FSM
// state encoding and a single-byte lookup helper used by every S-box lane.
package aes_pkg;

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  localparam logic [7:0] INV_SBOX [256] = '{
    8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
    8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
    8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
    8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
    8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
    8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
    8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
    8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
    8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
    8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
    8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
    8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
    8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
    8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
    8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
    8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
  };

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } sbx_state_e;

  function automatic logic [7:0] sbox_lookup(input logic [7:0] b, input logic inv);
    return inv ? INV_SBOX[b] : SBOX[b];
  endfunction

endpackage

// File: rtl/sbox_lane.sv
// One combinational S-box lane: forward or inverse substitution of a single byte.
module sbox_lane
  import aes_pkg::*;
(
  input  logic [7:0] data_i,
  input  logic       inv_i,
  output logic [7:0] data_o
);

  assign data_o = sbox_lookup(data_i, inv_i);

endmodule

// File: rtl/sub_bytes_seq.sv
// Iterative SubBytes engine: substitutes LANES bytes of the held state per
// cycle, in place, then presents the whole block with a valid/ready handshake.
module sub_bytes_seq
  import aes_pkg::*;
#(
  parameter int LANES = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_state,
  input  logic         in_inv,
  input  logic         clr,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_state,
  output logic         busy
);

  localparam int NUM_BEATS = 16 / LANES;
  localparam int CNT_W     = (NUM_BEATS > 1) ? $clog2(NUM_BEATS) : 1;
  localparam int BEAT_W    = LANES * 8;

  if (LANES != 1 && LANES != 2 && LANES != 4 && LANES != 8 && LANES != 16) begin : g_bad_lanes
    $error("sub_bytes_seq: LANES must be 1, 2, 4, 8 or 16 (got %0d)", LANES);
  end

  sbx_state_e        state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [127:0]      data_q;
  logic              inv_q;
  logic              in_ready_q;
  logic              out_valid_q;
  logic              busy_q;
  logic [BEAT_W-1:0] beat_in;
  logic [BEAT_W-1:0] beat_out;
  logic              last_beat;

  // The beat counter picks which slice of the block goes through the lanes.
  assign beat_in   = data_q[cnt_q*BEAT_W +: BEAT_W];
  assign last_beat = (cnt_q == CNT_W'(NUM_BEATS - 1));

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    sbox_lane u_lane (
      .data_i (beat_in[8*l +: 8]),
      .inv_i  (inv_q),
      .data_o (beat_out[8*l +: 8])
    );
  end

  // NOTE: state registers use non-blocking assignments so every register
  // samples the pre-edge values and the block models real flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      data_q      <= '0;
      inv_q       <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else if (clr) begin
      // Abort keeps the data register; consumers qualify it with out_valid.
      state_q     <= IDLE;
      cnt_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (in_valid) begin
            data_q     <= in_state;
            inv_q      <= in_inv;
            cnt_q      <= '0;
            state_q    <= BUSY;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
          end
        end
        BUSY: begin
          data_q[cnt_q*BEAT_W +: BEAT_W] <= beat_out;
          if (last_beat) begin
            cnt_q       <= '0;
            state_q     <= DONE;
            out_valid_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
          end
        end
        default: begin
          state_q     <= IDLE;
          cnt_q       <= '0;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign out_state = data_q;

endmodule

// File: tb/tb_sub_bytes_seq.sv
// Bench for sub_bytes_seq: three instances (LANES 1, 4, 16) checked against an
// S-box model derived from GF(2^8) inversion plus the AES affine transform.
module tb_sub_bytes_seq;

  logic         clk;
  logic         rst_n;
  logic [2:0]   in_valid;
  logic [2:0]   in_inv;
  logic [2:0]   clr;
  logic [2:0]   out_ready;
  logic [127:0] in_state [3];
  wire  [2:0]   in_ready;
  wire  [2:0]   out_valid;
  wire  [2:0]   busy;
  wire  [127:0] out_state [3];

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] fwd_tab [256];
  logic [7:0] inv_tab [256];

  localparam logic [127:0] FIPS_IN  = 128'h0848f8e92a8dc69a2be2f4a0bee33d19;
  localparam logic [127:0] FIPS_OUT = 128'h3052411ee55db4b8f198bfe0ae1127d4;

  sub_bytes_seq #(.LANES(1)) u_l1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .in_state(in_state[0]), .in_inv(in_inv[0]), .clr(clr[0]), .out_valid(out_valid[0]),
    .out_ready(out_ready[0]), .out_state(out_state[0]), .busy(busy[0])
  );

  sub_bytes_seq #(.LANES(4)) u_l4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .in_state(in_state[1]), .in_inv(in_inv[1]), .clr(clr[1]), .out_valid(out_valid[1]),
    .out_ready(out_ready[1]), .out_state(out_state[1]), .busy(busy[1])
  );

  sub_bytes_seq #(.LANES(16)) u_l16 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
    .in_state(in_state[2]), .in_inv(in_inv[2]), .clr(clr[2]), .out_valid(out_valid[2]),
    .out_ready(out_ready[2]), .out_state(out_state[2]), .busy(busy[2])
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic       hi;
    p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      hi = a[7];
      a  = {a[6:0], 1'b0};
      if (hi) a = a ^ 8'h1b;
      b = {1'b0, b[7:1]};
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
    return (v << n) | (v >> (8 - n));
  endfunction

  task automatic build_tables();
    logic [7:0] x, y, xi, s;
    for (int i = 0; i < 256; i++) begin
      x  = 8'(i);
      xi = 8'h00;
      for (int j = 1; j < 256; j++) begin
        y = 8'(j);
        if (gf_mul(x, y) == 8'h01) xi = y;
      end
      s = xi ^ rotl8(xi, 1) ^ rotl8(xi, 2) ^ rotl8(xi, 3) ^ rotl8(xi, 4) ^ 8'h63;
      fwd_tab[i] = s;
      inv_tab[s] = x;
    end
  endtask

  function automatic logic [127:0] model_sub(input logic [127:0] d, input logic inv);
    logic [127:0] r;
    for (int b = 0; b < 16; b++)
      r[8*b +: 8] = inv ? inv_tab[d[8*b +: 8]] : fwd_tab[d[8*b +: 8]];
    return r;
  endfunction

  function automatic int lanes_of(input int d);
    return (d == 0) ? 1 : (d == 1) ? 4 : 16;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Push one block through instance d and drain it with a one-cycle out_ready.
  task automatic run_block(input int d, input logic [127:0] data, input logic inv,
                           input bit toggle_inv, input bit hold_valid,
                           output logic [127:0] res, output int lat,
                           output bit busy_ok, output bit post_ok);
    busy_ok = 1'b1;
    lat     = 0;
    in_state[d] = data;
    in_inv[d]   = inv;
    in_valid[d] = 1'b1;
    @(posedge clk); #1;
    if (!hold_valid) in_valid[d] = 1'b0;
    in_state[d] = rand128();
    while (!out_valid[d] && lat < 40) begin
      if (!busy[d] || in_ready[d]) busy_ok = 1'b0;
      if (toggle_inv && lat == 0) in_inv[d] = ~inv;
      @(posedge clk); #1;
      lat++;
    end
    n_checks++;
    if (!out_valid[d]) begin
      n_fail++;
      $display("FAIL out_valid_timeout lanes=%0d: out_valid=%b after %0d cycles, required 1",
               lanes_of(d), out_valid[d], lat);
    end
    if (!busy[d] || in_ready[d]) busy_ok = 1'b0;
    res = out_state[d];
    out_ready[d] = 1'b1;
    @(posedge clk); #1;
    out_ready[d] = 1'b0;
    in_valid[d]  = 1'b0;
    in_inv[d]    = 1'b0;
    post_ok = in_ready[d] && !out_valid[d] && !busy[d];
  endtask

  task automatic test_reset();
    for (int d = 0; d < 3; d++) begin
      n_checks++;
      if ({in_ready[d], out_valid[d], busy[d]} !== 3'b100) begin
        n_fail++;
        $display("FAIL reset_flags lanes=%0d: {in_ready,out_valid,busy}=%b, required 100",
                 lanes_of(d), {in_ready[d], out_valid[d], busy[d]});
      end
      n_checks++;
      if (out_state[d] !== 128'h0) begin
        n_fail++;
        $display("FAIL reset_out_state lanes=%0d: got %h, required 0", lanes_of(d), out_state[d]);
      end
    end
  endtask

  task automatic test_zero_forward();
    logic [127:0] res;
    int lat;
    bit bok, pok;
    run_block(1, 128'h0, 1'b0, 1'b0, 1'b0, res, lat, bok, pok);
    n_checks++;
    if (res !== {16{8'h63}}) begin
      n_fail++;
      $display("FAIL zero_fwd_data: got %h, required %h", res, {16{8'h63}});
    end
    n_checks++;
    if (lat !== 4) begin
      n_fail++;
      $display("FAIL zero_fwd_latency: got %0d, required 4", lat);
    end
    n_checks++;
    if (!bok || !pok) begin
      n_fail++;
      $display("FAIL zero_fwd_busy: busy_ok=%b post_ok=%b, required 1 1", bok, pok);
    end
  endtask

  task automatic test_fips();
    logic [127:0] res;
    int lat;
    bit bok, pok;
    for (int d = 0; d < 3; d += 2) begin
      run_block(d, FIPS_IN, 1'b0, 1'b0, 1'b0, res, lat, bok, pok);
      n_checks++;
      if (res !== FIPS_OUT) begin
        n_fail++;
        $display("FAIL fips_fwd lanes=%0d: got %h, required %h", lanes_of(d), res, FIPS_OUT);
      end
      n_checks++;
      if (lat !== 16 / lanes_of(d)) begin
        n_fail++;
        $display("FAIL fips_latency lanes=%0d: got %0d, required %0d", lanes_of(d), lat, 16 / lanes_of(d));
      end
    end
  endtask

  task automatic test_inverse();
    logic [127:0] res;
    int lat;
    bit bok, pok;
    run_block(1, FIPS_OUT, 1'b1, 1'b0, 1'b0, res, lat, bok, pok);
    n_checks++;
    if (res !== FIPS_IN) begin
      n_fail++;
      $display("FAIL inverse: got %h, required %h", res, FIPS_IN);
    end
    run_block(1, FIPS_OUT, 1'b1, 1'b1, 1'b0, res, lat, bok, pok);
    n_checks++;
    if (res !== FIPS_IN) begin
      n_fail++;
      $display("FAIL inverse_toggle_mode: got %h, required %h", res, FIPS_IN);
    end
  endtask

  task automatic test_random();
    logic [127:0] data, res, exp;
    logic inv;
    int lat;
    bit bok, pok;
    for (int n = 0; n < 12; n++) begin
      int d;
      d    = n % 3;
      data = rand128();
      inv  = 1'($urandom_range(0, 1));
      exp  = model_sub(data, inv);
      run_block(d, data, inv, 1'($urandom_range(0, 1)), 1'b1, res, lat, bok, pok);
      n_checks++;
      if (res !== exp || lat !== 16 / lanes_of(d) || !bok || !pok) begin
        n_fail++;
        $display("FAIL random lanes=%0d inv=%b: got %h lat=%0d busy_ok=%b post_ok=%b, required %h lat=%0d 1 1",
                 lanes_of(d), inv, res, lat, bok, pok, exp, 16 / lanes_of(d));
      end
    end
  endtask

  task automatic test_backpressure();
    logic [127:0] data, held, res;
    int waited, lat;
    bit bok, pok;
    data = rand128();
    in_state[1] = data;
    in_inv[1]   = 1'b0;
    in_valid[1] = 1'b1;
    @(posedge clk); #1;
    in_valid[1] = 1'b0;
    waited = 0;
    while (!out_valid[1] && waited < 40) begin
      @(posedge clk); #1;
      waited++;
    end
    held = out_state[1];
    n_checks++;
    if (held !== model_sub(data, 1'b0)) begin
      n_fail++;
      $display("FAIL backpressure_data: got %h, required %h", held, model_sub(data, 1'b0));
    end
    for (int c = 0; c < 10; c++) begin
      in_inv[1] = ~in_inv[1];
      @(posedge clk); #1;
      n_checks++;
      if (!out_valid[1] || in_ready[1] || !busy[1] || out_state[1] !== held) begin
        n_fail++;
        $display("FAIL backpressure_hold cycle %0d: out_valid=%b in_ready=%b busy=%b out_state=%h, required 1 0 1 %h",
                 c, out_valid[1], in_ready[1], busy[1], out_state[1], held);
      end
    end
    in_inv[1]    = 1'b0;
    out_ready[1] = 1'b1;
    @(posedge clk); #1;
    out_ready[1] = 1'b0;
    n_checks++;
    if (!in_ready[1] || out_valid[1]) begin
      n_fail++;
      $display("FAIL backpressure_release: in_ready=%b out_valid=%b, required 1 0", in_ready[1], out_valid[1]);
    end
    run_block(1, {16{8'h53}}, 1'b0, 1'b0, 1'b0, res, lat, bok, pok);
    n_checks++;
    if (res !== {16{8'hed}}) begin
      n_fail++;
      $display("FAIL second_block_53: got %h, required %h", res, {16{8'hed}});
    end
  endtask

  task automatic test_clr_abort();
    bit seen;
    in_state[1] = rand128();
    in_valid[1] = 1'b1;
    @(posedge clk); #1;
    in_valid[1] = 1'b0;
    @(posedge clk); #1;
    clr[1] = 1'b1;
    @(posedge clk); #1;
    clr[1] = 1'b0;
    n_checks++;
    if (!in_ready[1] || out_valid[1] || busy[1]) begin
      n_fail++;
      $display("FAIL clr_abort: in_ready=%b out_valid=%b busy=%b, required 1 0 0",
               in_ready[1], out_valid[1], busy[1]);
    end
    seen = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(posedge clk); #1;
      if (out_valid[1]) seen = 1'b1;
    end
    n_checks++;
    if (seen) begin
      n_fail++;
      $display("FAIL clr_no_out_valid: out_valid rose=%b, required 0", seen);
    end
  endtask

  task automatic test_clr_vs_valid();
    in_state[1] = rand128();
    in_valid[1] = 1'b1;
    clr[1]      = 1'b1;
    @(posedge clk); #1;
    in_valid[1] = 1'b0;
    clr[1]      = 1'b0;
    n_checks++;
    if (!in_ready[1] || busy[1]) begin
      n_fail++;
      $display("FAIL clr_beats_valid: in_ready=%b busy=%b, required 1 0", in_ready[1], busy[1]);
    end
  endtask

  task automatic test_async_reset();
    in_state[1] = rand128();
    in_valid[1] = 1'b1;
    @(posedge clk); #1;
    in_valid[1] = 1'b0;
    @(posedge clk); #1;
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({in_ready[1], out_valid[1], busy[1]} !== 3'b100 || out_state[1] !== 128'h0) begin
      n_fail++;
      $display("FAIL async_reset: {in_ready,out_valid,busy}=%b out_state=%h, required 100 0",
               {in_ready[1], out_valid[1], busy[1]}, out_state[1]);
    end
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if (!in_ready[1] || out_valid[1]) begin
      n_fail++;
      $display("FAIL after_async_reset: in_ready=%b out_valid=%b, required 1 0", in_ready[1], out_valid[1]);
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = '0;
    in_inv    = '0;
    clr       = '0;
    out_ready = '0;
    for (int d = 0; d < 3; d++) in_state[d] = '0;
    build_tables();
    #22 rst_n = 1'b1;
    @(posedge clk); #1;

    test_reset();
    test_zero_forward();
    test_fips();
    test_inverse();
    test_random();
    test_backpressure();
    test_clr_abort();
    test_clr_vs_valid();
    test_async_reset();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
